// File: rtl/direction_pkg.sv
// Shared constants and state encoding for the direction-of-arrival tracker.
package direction_pkg;
  localparam int NUM_BINS = 16;
  localparam int BIN_W    = 4;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    VOTE    = 2'd2,
    TRACK   = 2'd3
  } tracker_state_t;
endpackage

// File: rtl/bin_histogram.sv
// Sixteen saturating 4-bit vote counters with synchronous clear,
// one increment port and one combinational read port.
module bin_histogram
  import direction_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clear,
  input  logic             inc,
  input  logic [BIN_W-1:0] inc_idx,
  input  logic [BIN_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt
);

  logic [CNT_W-1:0] cnt [NUM_BINS];

  // NOTE: this array is tiny and must read as zero straight after reset, so it
  // is built from resettable flops rather than treated as an uninitialised RAM.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || clear) begin
      for (int i = 0; i < NUM_BINS; i++) cnt[i] <= '0;
    end else if (inc && (cnt[inc_idx] != '1)) begin
      cnt[inc_idx] <= cnt[inc_idx] + 1'b1;
    end
  end

  assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/direction_tracker.sv
// Collects per-frame bin estimates after a wake pulse, votes for the most
// frequent bin, then holds and slowly retargets it while a keyword is active.
module direction_tracker
  import direction_pkg::*;
#(
  parameter int ACQ_FRAMES  = 8,
  parameter int ACQ_TIMEOUT = 49_152_000,
  parameter int HOLD_CYCLES = 196_608_000,
  parameter int CONFIRM     = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_valid_in,
  input  logic             wake_in,
  output logic [BIN_W-1:0] bin,
  output logic             recognised,
  output logic [1:0]       state_out
);

  localparam int TMO_W  = (ACQ_TIMEOUT > 1) ? $clog2(ACQ_TIMEOUT) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(ACQ_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]        FRAMES_LAST = 4'(ACQ_FRAMES - 1);
  localparam logic [2:0]        RUN_DONE    = 3'(CONFIRM);
  localparam logic [BIN_W-1:0]  SCAN_LAST   = BIN_W'(NUM_BINS - 1);

  tracker_state_t    state;
  logic [3:0]        frame_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [BIN_W-1:0]  scan_idx;
  logic [CNT_W-1:0]  best_cnt;
  logic [BIN_W-1:0]  best_idx;
  logic [BIN_W-1:0]  cand;
  logic [2:0]        run;

  logic              hist_clear;
  logic              hist_inc;
  logic [CNT_W-1:0]  rd_cnt;
  logic              new_best;
  logic [BIN_W-1:0]  winner;

  assign hist_clear = (state == IDLE);
  assign hist_inc   = (state == ACQUIRE) && bin_valid_in;

  bin_histogram u_hist (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear    (hist_clear),
    .inc      (hist_inc),
    .inc_idx  (bin_in),
    .rd_idx   (scan_idx),
    .rd_cnt   (rd_cnt)
  );

  // Strict greater-than keeps the earliest (lowest) index on ties.
  assign new_best = (scan_idx == '0) || (rd_cnt > best_cnt);
  assign winner   = new_best ? scan_idx : best_idx;

  assign state_out = state;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // sees the pre-edge values, matching the flop behaviour being described.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      bin        <= '0;
      recognised <= 1'b0;
      frame_cnt  <= '0;
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
      scan_idx   <= '0;
      best_cnt   <= '0;
      best_idx   <= '0;
      cand       <= '0;
      run        <= '0;
    end else begin
      case (state)
        IDLE: begin
          frame_cnt <= '0;
          tmo_cnt   <= '0;
          scan_idx  <= '0;
          best_cnt  <= '0;
          best_idx  <= '0;
          cand      <= '0;
          run       <= '0;
          if (wake_in) state <= ACQUIRE;
        end

        ACQUIRE: begin
          if (bin_valid_in) frame_cnt <= frame_cnt + 1'b1;
          // Reaching the frame quota beats a timeout landing in the same cycle.
          if (bin_valid_in && (frame_cnt == FRAMES_LAST)) begin
            state    <= VOTE;
            scan_idx <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        VOTE: begin
          if (new_best) begin
            best_cnt <= rd_cnt;
            best_idx <= scan_idx;
          end
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == SCAN_LAST) begin
            bin        <= winner;
            recognised <= 1'b1;
            hold_cnt   <= HOLD_LOAD;
            state      <= TRACK;
          end
        end

        TRACK: begin
          if (wake_in) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            state      <= IDLE;
            recognised <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end

          if (run == RUN_DONE) begin
            bin <= cand;
            run <= '0;
          end else if (bin_valid_in) begin
            if (bin_in == bin) begin
              run <= '0;
            end else if (bin_in == cand) begin
              run <= run + 1'b1;
            end else begin
              cand <= bin_in;
              run  <= 3'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_direction_tracker.sv
// Self-checking bench for direction_tracker: directed scenarios plus randomized
// acquisitions and retarget sequences scored against a behavioural model.
module tb_direction_tracker;

  localparam int ACQ_FRAMES  = 8;
  localparam int ACQ_TIMEOUT = 1000;
  localparam int HOLD_CYCLES = 100;
  localparam int CONFIRM     = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACQ   = 2'd1;
  localparam logic [1:0] S_VOTE  = 2'd2;
  localparam logic [1:0] S_TRACK = 2'd3;

  logic       clk_in       = 1'b0;
  logic       rst_n_in     = 1'b0;
  logic [3:0] bin_in       = '0;
  logic       bin_valid_in = 1'b0;
  logic       wake_in      = 1'b0;
  logic [3:0] bin;
  logic       recognised;
  logic [1:0] state_out;

  int checks   = 0;
  int failures = 0;
  int frames [ACQ_FRAMES];

  direction_tracker #(
    .ACQ_FRAMES  (ACQ_FRAMES),
    .ACQ_TIMEOUT (ACQ_TIMEOUT),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CONFIRM     (CONFIRM)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .bin_in       (bin_in),
    .bin_valid_in (bin_valid_in),
    .wake_in      (wake_in),
    .bin          (bin),
    .recognised   (recognised),
    .state_out    (state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Wake pulse (optionally carrying a frame that must be ignored), then the frames.
  task automatic run_acquire(input int wake_frame, input bit gaps);
    wake_in      = 1'b1;
    bin_valid_in = (wake_frame >= 0);
    bin_in       = (wake_frame >= 0) ? 4'(wake_frame) : 4'd0;
    step();
    wake_in      = 1'b0;
    bin_valid_in = 1'b0;
    for (int i = 0; i < ACQ_FRAMES; i++) begin
      if (gaps) idle_steps($urandom_range(0, 2));
      bin_valid_in = 1'b1;
      bin_in       = 4'(frames[i]);
      step();
      bin_valid_in = 1'b0;
    end
  endtask

  task automatic drive_vote(input bit noisy, input int n);
    for (int i = 0; i < n; i++) begin
      if (noisy) begin
        wake_in      = 1'($urandom_range(0, 1));
        bin_valid_in = 1'($urandom_range(0, 1));
        bin_in       = 4'($urandom_range(0, 15));
      end
      step();
    end
    wake_in      = 1'b0;
    bin_valid_in = 1'b0;
  endtask

  // Mode of the frame list; the earliest bin wins any tie.
  function automatic int expected_winner();
    int cnt [16];
    int best;
    foreach (cnt[b]) cnt[b] = 0;
    foreach (frames[i]) cnt[frames[i]]++;
    best = 0;
    for (int b = 1; b < 16; b++) if (cnt[b] > cnt[best]) best = b;
    return best;
  endfunction

  task automatic test_reset();
    rst_n_in = 1'b0;
    idle_steps(2);
    checks++; if (bin !== 4'd0) begin failures++; $display("FAIL reset_bin got=%0d exp=0", bin); end
    checks++; if (recognised !== 1'b0) begin failures++; $display("FAIL reset_rec got=%0b exp=0", recognised); end
    checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_out, S_IDLE); end
    rst_n_in = 1'b1;
    step();
    checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL reset_stay_idle got=%0d exp=%0d", state_out, S_IDLE); end
  endtask

  task automatic test_lock_basic();
    frames = '{5, 5, 5, 4, 5, 6, 5, 5};
    run_acquire(-1, 1'b0);
    checks++; if (state_out !== S_VOTE) begin failures++; $display("FAIL basic_vote_state got=%0d exp=%0d", state_out, S_VOTE); end
    drive_vote(1'b0, 15);
    checks++; if (recognised !== 1'b0) begin failures++; $display("FAIL basic_rec_early got=%0b exp=0", recognised); end
    drive_vote(1'b0, 1);
    checks++; if (recognised !== 1'b1) begin failures++; $display("FAIL basic_rec got=%0b exp=1", recognised); end
    checks++; if (bin !== 4'd5) begin failures++; $display("FAIL basic_bin got=%0d exp=5", bin); end
    checks++; if (state_out !== S_TRACK) begin failures++; $display("FAIL basic_track got=%0d exp=%0d", state_out, S_TRACK); end
    idle_steps(HOLD_CYCLES - 1);
    checks++; if (recognised !== 1'b1) begin failures++; $display("FAIL basic_hold_rec got=%0b exp=1", recognised); end
    step();
    checks++; if (recognised !== 1'b0) begin failures++; $display("FAIL basic_expire_rec got=%0b exp=0", recognised); end
    checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL basic_expire_state got=%0d exp=%0d", state_out, S_IDLE); end
    checks++; if (bin !== 4'd5) begin failures++; $display("FAIL basic_bin_held got=%0d exp=5", bin); end
  endtask

  task automatic test_tie();
    frames = '{3, 3, 3, 9, 9, 9, 1, 1};
    run_acquire(9, 1'b0);
    checks++; if (state_out !== S_VOTE) begin failures++; $display("FAIL tie_vote_state got=%0d exp=%0d", state_out, S_VOTE); end
    drive_vote(1'b0, 15);
    checks++; if (recognised !== 1'b0) begin failures++; $display("FAIL tie_rec_early got=%0b exp=0", recognised); end
    drive_vote(1'b0, 1);
    checks++; if (bin !== 4'd3) begin failures++; $display("FAIL tie_bin got=%0d exp=3", bin); end
    checks++; if (recognised !== 1'b1) begin failures++; $display("FAIL tie_rec got=%0b exp=1", recognised); end
    idle_steps(HOLD_CYCLES);
    checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL tie_expire got=%0d exp=%0d", state_out, S_IDLE); end
  endtask

  task automatic test_random_lock();
    for (int it = 0; it < 6; it++) begin
      int fav;
      int exp_bin;
      fav = $urandom_range(0, 15);
      foreach (frames[i]) frames[i] = ($urandom_range(0, 1) == 1) ? fav : int'($urandom_range(0, 15));
      exp_bin = expected_winner();
      run_acquire(-1, 1'b1);
      checks++; if (state_out !== S_VOTE) begin failures++; $display("FAIL rand_vote_state it=%0d got=%0d exp=%0d", it, state_out, S_VOTE); end
      drive_vote(1'b1, 15);
      checks++; if (recognised !== 1'b0) begin failures++; $display("FAIL rand_rec_early it=%0d got=%0b exp=0", it, recognised); end
      drive_vote(1'b1, 1);
      checks++; if (bin !== 4'(exp_bin)) begin failures++; $display("FAIL rand_bin it=%0d got=%0d exp=%0d", it, bin, exp_bin); end
      checks++; if (recognised !== 1'b1) begin failures++; $display("FAIL rand_rec it=%0d got=%0b exp=1", it, recognised); end
      idle_steps(HOLD_CYCLES);
      checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL rand_expire it=%0d got=%0d exp=%0d", it, state_out, S_IDLE); end
    end
  endtask

  task automatic test_timeout();
    bit rec_seen;
    rec_seen = 1'b0;
    wake_in = 1'b1;
    step();
    wake_in = 1'b0;
    checks++; if (state_out !== S_ACQ) begin failures++; $display("FAIL tmo_acq_state got=%0d exp=%0d", state_out, S_ACQ); end
    for (int i = 0; i < 5; i++) begin
      bin_valid_in = 1'b1;
      bin_in       = 4'($urandom_range(0, 15));
      step();
      bin_valid_in = 1'b0;
      rec_seen |= recognised;
    end
    for (int i = 0; i < ACQ_TIMEOUT - 6; i++) begin
      step();
      rec_seen |= recognised;
    end
    checks++; if (state_out !== S_ACQ) begin failures++; $display("FAIL tmo_before got=%0d exp=%0d", state_out, S_ACQ); end
    step();
    rec_seen |= recognised;
    checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL tmo_idle got=%0d exp=%0d", state_out, S_IDLE); end
    checks++; if (rec_seen !== 1'b0) begin failures++; $display("FAIL tmo_rec got=%0b exp=0", rec_seen); end
  endtask

  task automatic test_retarget();
    int seq [6];
    int exp_seq [6];
    int cyc;
    seq     = '{7, 7, 2, 7, 7, 7};
    exp_seq = '{5, 5, 5, 5, 5, 7};
    foreach (frames[i]) frames[i] = 5;
    run_acquire(-1, 1'b0);
    drive_vote(1'b0, 16);
    checks++; if (bin !== 4'd5) begin failures++; $display("FAIL rt_lock_bin got=%0d exp=5", bin); end
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      bin_valid_in = 1'b1;
      bin_in       = 4'(seq[i]);
      step();
      bin_valid_in = 1'b0;
      step();
      cyc += 2;
      checks++; if (bin !== 4'(exp_seq[i])) begin failures++; $display("FAIL rt_bin idx=%0d got=%0d exp=%0d", i, bin, exp_seq[i]); end
    end
    idle_steps(HOLD_CYCLES - 1 - cyc);
    checks++; if (state_out !== S_TRACK) begin failures++; $display("FAIL rt_pre_wake got=%0d exp=%0d", state_out, S_TRACK); end
    wake_in = 1'b1;
    step();
    wake_in = 1'b0;
    checks++; if (state_out !== S_TRACK) begin failures++; $display("FAIL rt_wake_state got=%0d exp=%0d", state_out, S_TRACK); end
    checks++; if (recognised !== 1'b1) begin failures++; $display("FAIL rt_wake_rec got=%0b exp=1", recognised); end
    idle_steps(HOLD_CYCLES - 1);
    checks++; if (state_out !== S_TRACK) begin failures++; $display("FAIL rt_reload_hold got=%0d exp=%0d", state_out, S_TRACK); end
    step();
    checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL rt_reload_expire got=%0d exp=%0d", state_out, S_IDLE); end
    checks++; if (bin !== 4'd7) begin failures++; $display("FAIL rt_final_bin got=%0d exp=7", bin); end
  endtask

  // Model: the target moves to v once the last CONFIRM frames since the
  // previous move are all v and v differs from the current target.
  task automatic test_random_retarget();
    int start;
    int cur;
    int pool [3];
    int q [$];
    start = $urandom_range(0, 15);
    foreach (frames[i]) frames[i] = start;
    run_acquire(-1, 1'b0);
    drive_vote(1'b0, 16);
    checks++; if (bin !== 4'(start)) begin failures++; $display("FAIL rrt_lock_bin got=%0d exp=%0d", bin, start); end
    cur     = start;
    pool[0] = start;
    pool[1] = $urandom_range(0, 15);
    pool[2] = $urandom_range(0, 15);
    for (int n = 0; n < 30; n++) begin
      int v;
      bit same;
      v = pool[$urandom_range(0, 2)];
      wake_in      = 1'b1;
      bin_valid_in = 1'b1;
      bin_in       = 4'(v);
      step();
      wake_in      = 1'b0;
      bin_valid_in = 1'b0;
      step();
      q.push_back(v);
      if (q.size() >= CONFIRM) begin
        same = 1'b1;
        for (int k = q.size() - CONFIRM; k < q.size(); k++) if (q[k] != v) same = 1'b0;
        if (same && (v != cur)) begin
          cur = v;
          q.delete();
        end
      end
      checks++; if (bin !== 4'(cur)) begin failures++; $display("FAIL rrt_bin n=%0d got=%0d exp=%0d", n, bin, cur); end
    end
    idle_steps(HOLD_CYCLES - 1);
    checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL rrt_expire got=%0d exp=%0d", state_out, S_IDLE); end
  endtask

  task automatic test_reset_mid_track();
    foreach (frames[i]) frames[i] = 12;
    run_acquire(-1, 1'b0);
    drive_vote(1'b0, 16);
    idle_steps(10);
    checks++; if (bin !== 4'd12) begin failures++; $display("FAIL rtrk_pre_bin got=%0d exp=12", bin); end
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    checks++; if (bin !== 4'd0) begin failures++; $display("FAIL rtrk_bin got=%0d exp=0", bin); end
    checks++; if (recognised !== 1'b0) begin failures++; $display("FAIL rtrk_rec got=%0b exp=0", recognised); end
    checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL rtrk_state got=%0d exp=%0d", state_out, S_IDLE); end
  endtask

  task automatic test_reset_mid_vote();
    foreach (frames[i]) frames[i] = 6;
    run_acquire(-1, 1'b0);
    drive_vote(1'b0, 16);
    idle_steps(HOLD_CYCLES);
    checks++; if (bin !== 4'd6) begin failures++; $display("FAIL rvote_pre_bin got=%0d exp=6", bin); end
    foreach (frames[i]) frames[i] = $urandom_range(0, 15);
    run_acquire(-1, 1'b0);
    drive_vote(1'b0, 7);
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    checks++; if (bin !== 4'd0) begin failures++; $display("FAIL rvote_bin got=%0d exp=0", bin); end
    checks++; if (recognised !== 1'b0) begin failures++; $display("FAIL rvote_rec got=%0b exp=0", recognised); end
    checks++; if (state_out !== S_IDLE) begin failures++; $display("FAIL rvote_state got=%0d exp=%0d", state_out, S_IDLE); end
    frames = '{2, 2, 8, 2, 8, 2, 0, 2};
    run_acquire(-1, 1'b0);
    drive_vote(1'b0, 16);
    checks++; if (bin !== 4'd2) begin failures++; $display("FAIL rvote_after_bin got=%0d exp=2", bin); end
    checks++; if (recognised !== 1'b1) begin failures++; $display("FAIL rvote_after_rec got=%0b exp=1", recognised); end
    idle_steps(HOLD_CYCLES);
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_tie();
    test_random_lock();
    test_timeout();
    test_retarget();
    test_random_retarget();
    test_reset_mid_track();
    test_reset_mid_vote();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
